param_universal_shifter: RTL

Parametrised universal shift register with a multi-step sequencer. One `start` command runs a chosen operation `count` times, one step per clock: logical shift, rotate, arithmetic shift or parallel load. A `busy`/`done` handshake and registered serial-out bits let a controller drive it as a serialiser or barrel-style shifter. It is the general-width successor to the team's fixed 4-bit universal shift register, for datapaths that need wider words and multi-bit shifts without a combinational barrel shifter.

---
 rtl/param_universal_shifter.sv | 113 +++++++++++
 1 files changed

// File: rtl/param_universal_shifter.sv
// Parametrised universal shift register with a multi-step sequencer: one start
// command runs a shift/rotate op count times, one step per clock, then pulses done.
module param_universal_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] data_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] rem;
  logic             accept_shift;

  function automatic logic is_shift_op(input logic [2:0] o);
    return (o == OP_SRL) || (o == OP_SHL) || (o == OP_ROR) ||
           (o == OP_ROL) || (o == OP_ASR);
  endfunction

  function automatic logic is_right_op(input logic [2:0] o);
    return (o == OP_SRL) || (o == OP_ROR) || (o == OP_ASR);
  endfunction

  function automatic logic is_left_op(input logic [2:0] o);
    return (o == OP_SHL) || (o == OP_ROL);
  endfunction

  function automatic logic [WIDTH-1:0] step_data(input logic [2:0]       o,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic             mi,
                                                 input logic             li);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SRL:  r = {mi, d[WIDTH-1:1]};
      OP_SHL:  r = {d[WIDTH-2:0], li};
      OP_ROR:  r = {d[0], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_ASR:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept_shift = start && is_shift_op(op) && (count != '0);
  assign busy         = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_shift) state_nxt = SHIFT;
      SHIFT:   if (rem == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Commands are only sampled in IDLE; in SHIFT everything runs off op_q/rem.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_HOLD;
      rem      <= '0;
      data_out <= '0;
      msb_out  <= 1'b0;
      lsb_out  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_shift) begin
            op_q <= op;
            rem  <= count;
          end else if (start) begin
            done <= 1'b1;
            if (op == OP_LOAD) data_out <= data_in;
          end
        end
        SHIFT: begin
          data_out <= step_data(op_q, data_out, msb_in, lsb_in);
          rem      <= rem - CNT_W'(1);
          if (is_right_op(op_q)) lsb_out <= data_out[0];
          if (is_left_op(op_q))  msb_out <= data_out[WIDTH-1];
          if (rem == CNT_W'(1))  done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
